rat_irq_controller: RTL and testbench

- Parametrised interrupt controller for the RAT MCU; generalises the single keypad/button interrupt line to NUM_IRQ independent sources.
- Synchronises and rising-edge-detects each source, then latches it as a pending bit.
- Pending/mask/ack/ID registers are port-mapped on the MCU I/O bus (port_id/out_port/io_strb/in_port).
- Drives the MCU interrupt input in level mode or stretched-pulse mode; sits in the wrapper between peripherals and the MCU.

---
 rtl/rat_irq_controller_if.sv | 19 +
 rtl/rat_irq_controller.sv | 152 +++++++++++++++
 tb/tb_rat_irq_controller.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rat_irq_controller_if.sv
// MCU port-mapped I/O bus as seen by the interrupt controller.
// The master drives the port ID and write data; the slave returns read data and hit.
interface rat_irq_controller_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id, out_port, io_strb,
    input  rd_data, rd_hit
  );

  modport slave (
    input  port_id, out_port, io_strb,
    output rd_data, rd_hit
  );
endinterface

// File: rtl/rat_irq_controller.sv
// Multi-source interrupt controller for the RAT MCU: synchronise, edge-detect and latch
// sources, expose PENDING/MASK/ACK/IRQ_ID on the I/O bus, and drive irq as a level or a pulse.
module rat_irq_controller #(
  parameter int         NUM_IRQ     = 4,
  parameter logic [7:0] BASE_ID     = 8'hF0,
  parameter int         SYNC_STAGES = 2,
  parameter bit         LEVEL_MODE  = 1'b0,
  parameter int         PULSE_LEN   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_IRQ-1:0]   irq_src,
  rat_irq_controller_if.slave  bus,
  output logic                 irq
);
  localparam logic [7:0] VALID    = 8'((1 << NUM_IRQ) - 1);
  localparam logic [3:0] CNT_INIT = 4'(PULSE_LEN - 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  logic [NUM_IRQ-1:0] src_sync;
  logic [NUM_IRQ-1:0] hist_reg;
  logic [SYNC_STAGES:0] arm_reg;
  logic [7:0] rise_vec;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] mask_reg, mask_next;
  logic [7:0] act_vec;
  logic [7:0] irq_id;
  logic       act;
  logic       blk_sel, wr_mask, wr_ack;

  genvar gi;
  for (gi = 0; gi < NUM_IRQ; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_reg <= '0;
      else          sync_reg <= {sync_reg[SYNC_STAGES-2:0], irq_src[gi]};
    end
    assign src_sync[gi] = sync_reg[SYNC_STAGES-1];
  end

  // Edges are only trusted once the history flop holds post-reset data, so a
  // source already high at release is not mistaken for a new rising edge.
  always_comb begin
    rise_vec = '0;
    rise_vec[NUM_IRQ-1:0] = src_sync & ~hist_reg & {NUM_IRQ{arm_reg[SYNC_STAGES]}};
  end

  assign blk_sel = (bus.port_id[7:2] == BASE_ID[7:2]);
  assign wr_mask = bus.io_strb && blk_sel && (bus.port_id[1:0] == 2'd1);
  assign wr_ack  = bus.io_strb && blk_sel && (bus.port_id[1:0] == 2'd2);

  // A new edge overrides a same-cycle acknowledge of the same bit.
  assign pending_next = ((pending_reg & ~(wr_ack ? bus.out_port : 8'h00)) | rise_vec) & VALID;
  assign mask_next    = wr_mask ? (bus.out_port & VALID) : mask_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_reg    <= '0;
      arm_reg     <= '0;
      pending_reg <= '0;
      mask_reg    <= '0;
    end else begin
      hist_reg    <= src_sync;
      arm_reg     <= {arm_reg[SYNC_STAGES-1:0], 1'b1};
      pending_reg <= pending_next;
      mask_reg    <= mask_next;
    end
  end

  assign act_vec = pending_reg & mask_reg;
  assign act     = |act_vec;

  always_comb begin
    irq_id = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (act_vec[i]) irq_id = {1'b1, 4'b0000, i[2:0]};
    end
  end

  always_comb begin
    bus.rd_data = 8'h00;
    bus.rd_hit  = 1'b0;
    if (blk_sel) begin
      case (bus.port_id[1:0])
        2'd0: begin bus.rd_data = pending_reg; bus.rd_hit = 1'b1; end
        2'd1: begin bus.rd_data = mask_reg;    bus.rd_hit = 1'b1; end
        2'd3: begin bus.rd_data = irq_id;      bus.rd_hit = 1'b1; end
        default: ;
      endcase
    end
  end

  if (LEVEL_MODE) begin : g_level
    logic irq_reg;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq_reg <= 1'b0;
      else          irq_reg <= act;
    end
    assign irq = irq_reg;
  end else begin : g_pulse
    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       irq_reg, irq_next;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        irq_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        irq_reg   <= irq_next;
      end
    end

    // HOLD leaves on any ACK so sources still pending after service fire again.
    always_comb begin
      state_next = state_reg;
      case (state_reg)
        IDLE:    if (act) state_next = PULSE;
        PULSE:   if (cnt_reg == 4'd0) state_next = HOLD;
        HOLD:    if (wr_ack || !act) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end

    always_comb begin
      cnt_next = cnt_reg;
      irq_next = 1'b0;
      case (state_reg)
        IDLE: begin
          if (act) begin
            irq_next = 1'b1;
            cnt_next = CNT_INIT;
          end
        end
        PULSE: begin
          if (cnt_reg == 4'd0) irq_next = 1'b0;
          else begin
            irq_next = 1'b1;
            cnt_next = cnt_reg - 4'd1;
          end
        end
        default: irq_next = 1'b0;
      endcase
    end

    assign irq = irq_reg;
  end
endmodule

// File: tb/tb_rat_irq_controller.sv
// Directed bench for rat_irq_controller: a pulse-mode and a level-mode instance
// sharing clock and reset, each with its own bus interface and sources.
module tb_rat_irq_controller;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] src_p, src_l;
  logic       irq_p, irq_l;
  int         n_cmp = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  rat_irq_controller_if bus_p ();
  rat_irq_controller_if bus_l ();

  rat_irq_controller #(
    .NUM_IRQ(4), .BASE_ID(8'hF0), .SYNC_STAGES(2), .LEVEL_MODE(1'b0), .PULSE_LEN(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .irq_src(src_p), .bus(bus_p), .irq(irq_p)
  );

  rat_irq_controller #(
    .NUM_IRQ(4), .BASE_ID(8'hF0), .SYNC_STAGES(2), .LEVEL_MODE(1'b1), .PULSE_LEN(4)
  ) dut_lvl (
    .clk(clk), .reset_n(reset_n), .irq_src(src_l), .bus(bus_l), .irq(irq_l)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input bit lvl, input logic [7:0] a, input logic [7:0] d);
    $display("wr %s port=%h data=%h", lvl ? "lvl" : "pls", a, d);
    if (lvl) begin bus_l.port_id = a; bus_l.out_port = d; bus_l.io_strb = 1'b1; end
    else     begin bus_p.port_id = a; bus_p.out_port = d; bus_p.io_strb = 1'b1; end
    tick(1);
    bus_l.io_strb = 1'b0; bus_l.port_id = 8'h00;
    bus_p.io_strb = 1'b0; bus_p.port_id = 8'h00;
  endtask

  task automatic rd(input bit lvl, input logic [7:0] a, output logic [7:0] d, output logic h);
    if (lvl) bus_l.port_id = a; else bus_p.port_id = a;
    #1;
    d = lvl ? bus_l.rd_data : bus_p.rd_data;
    h = lvl ? bus_l.rd_hit  : bus_p.rd_hit;
    $display("rd %s port=%h data=%h hit=%b", lvl ? "lvl" : "pls", a, d, h);
    bus_l.port_id = 8'h00;
    bus_p.port_id = 8'h00;
  endtask

  task automatic test_reset();
    logic [7:0] d; logic h;
    src_p = 4'b0001; src_l = 4'b0001;
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL reset_irq cyc=%0d got=%b exp=0", i, irq_p); end
      rd(0, 8'hF0, d, h);
      n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_pending cyc=%0d got=%h exp=00", i, d); end
    end
    rd(0, 8'hF1, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_mask got=%h exp=00", d); end
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL reset_irq_id got=%h exp=00", d); end
    src_p = 4'b0000; src_l = 4'b0000;
    tick(3);
  endtask

  task automatic test_single_edge();
    logic [7:0] d; logic h; int cnt;
    wr(0, 8'hF1, 8'h0F);
    rd(0, 8'hF1, d, h);
    n_cmp++; if (d !== 8'h0F || h !== 1'b1) begin n_fail++; $display("FAIL mask_rb got=%h/%b exp=0f/1", d, h); end
    src_p[2] = 1'b1;
    tick(2);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pend_early got=%h exp=00", d); end
    tick(1);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h04) begin n_fail++; $display("FAIL pend_t3 got=%h exp=04", d); end
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h82) begin n_fail++; $display("FAIL irq_id_2 got=%h exp=82", d); end
    n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL irq_pre got=%b exp=0", irq_p); end
    tick(1);
    n_cmp++; if (irq_p !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b exp=1", irq_p); end
    cnt = 1;
    for (int i = 0; i < 9; i++) begin tick(1); if (irq_p === 1'b1) cnt++; end
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL pulse_len got=%0d exp=4", cnt); end
    rd(0, 8'hF2, d, h);
    n_cmp++; if (d !== 8'h00 || h !== 1'b0) begin n_fail++; $display("FAIL ack_read got=%h/%b exp=00/0", d, h); end
    rd(0, 8'hF0, d, h);
    n_cmp++; if (h !== 1'b1) begin n_fail++; $display("FAIL hit_pend got=%b exp=1", h); end
    rd(0, 8'hF4, d, h);
    n_cmp++; if (d !== 8'h00 || h !== 1'b0) begin n_fail++; $display("FAIL hit_outside got=%h/%b exp=00/0", d, h); end
    wr(0, 8'hF2, 8'h04);
    src_p[2] = 1'b0;
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pend_acked got=%h exp=00", d); end
    tick(3);
    n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL irq_after_ack got=%b exp=0", irq_p); end
  endtask

  task automatic test_two_sources();
    logic [7:0] d; logic h; int cnt;
    src_p = 4'b1010;
    tick(3);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h0A) begin n_fail++; $display("FAIL pend_two got=%h exp=0a", d); end
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h81) begin n_fail++; $display("FAIL irq_id_1 got=%h exp=81", d); end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (irq_p === 1'b1) cnt++; end
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL pulse_first got=%0d exp=4", cnt); end
    wr(0, 8'hF2, 8'h02);
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h83) begin n_fail++; $display("FAIL irq_id_3 got=%h exp=83", d); end
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(1); if (irq_p === 1'b1) cnt++; end
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL pulse_refire got=%0d exp=4", cnt); end
    wr(0, 8'hF2, 8'h08);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin tick(1); if (irq_p === 1'b1) cnt++; end
    n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL no_third_pulse got=%0d exp=0", cnt); end
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pend_clear got=%h exp=00", d); end
    src_p = 4'b0000;
    tick(3);
  endtask

  task automatic test_masked();
    logic [7:0] d; logic h; int cnt;
    wr(0, 8'hF1, 8'h00);
    src_p[0] = 1'b1;
    tick(3);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL pend_masked got=%h exp=01", d); end
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL irq_id_masked got=%h exp=00", d); end
    cnt = 0;
    for (int i = 0; i < 5; i++) begin tick(1); if (irq_p === 1'b1) cnt++; end
    n_cmp++; if (cnt != 0) begin n_fail++; $display("FAIL irq_masked got=%0d exp=0", cnt); end
    wr(0, 8'hF1, 8'h01);
    tick(1);
    n_cmp++; if (irq_p !== 1'b1) begin n_fail++; $display("FAIL irq_unmask got=%b exp=1", irq_p); end
    tick(6);
    wr(0, 8'hF2, 8'h01);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pend_unmask_ack got=%h exp=00", d); end
    src_p[0] = 1'b0;
    tick(3);
  endtask

  task automatic test_ack_collision();
    logic [7:0] d; logic h;
    src_p[0] = 1'b1;
    tick(2);
    wr(0, 8'hF2, 8'h01);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL set_wins got=%h exp=01", d); end
    tick(8);
    wr(0, 8'hF2, 8'h01);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL pend_after_collision got=%h exp=00", d); end
    src_p[0] = 1'b0;
    tick(3);
    n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL irq_after_collision got=%b exp=0", irq_p); end
  endtask

  task automatic test_level();
    logic [7:0] d; logic h;
    wr(1, 8'hF1, 8'h01);
    src_l[0] = 1'b1;
    tick(3);
    rd(1, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h01) begin n_fail++; $display("FAIL lvl_pend got=%h exp=01", d); end
    n_cmp++; if (irq_l !== 1'b0) begin n_fail++; $display("FAIL lvl_irq_lag got=%b exp=0", irq_l); end
    tick(1);
    n_cmp++; if (irq_l !== 1'b1) begin n_fail++; $display("FAIL lvl_irq_rise got=%b exp=1", irq_l); end
    tick(5);
    n_cmp++; if (irq_l !== 1'b1) begin n_fail++; $display("FAIL lvl_irq_hold got=%b exp=1", irq_l); end
    wr(1, 8'hF2, 8'h01);
    n_cmp++; if (irq_l !== 1'b1) begin n_fail++; $display("FAIL lvl_irq_ack_edge got=%b exp=1", irq_l); end
    tick(1);
    n_cmp++; if (irq_l !== 1'b0) begin n_fail++; $display("FAIL lvl_irq_fall got=%b exp=0", irq_l); end
    src_l[0] = 1'b0;
    tick(3);
  endtask

  task automatic test_reset_mid_pulse();
    logic [7:0] d; logic h;
    wr(0, 8'hF1, 8'h0F);
    src_p[3] = 1'b1;
    tick(4);
    n_cmp++; if (irq_p !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_irq got=%b exp=1", irq_p); end
    tick(1);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq got=%b exp=0", irq_p); end
    tick(2);
    reset_n = 1'b1;
    tick(4);
    rd(0, 8'hF0, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst2_pending got=%h exp=00", d); end
    rd(0, 8'hF1, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst2_mask got=%h exp=00", d); end
    rd(0, 8'hF3, d, h);
    n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL rst2_irq_id got=%h exp=00", d); end
    n_cmp++; if (irq_p !== 1'b0) begin n_fail++; $display("FAIL rst2_irq got=%b exp=0", irq_p); end
    src_p = 4'b0000;
  endtask

  initial begin
    bus_p.port_id = 8'h00; bus_p.out_port = 8'h00; bus_p.io_strb = 1'b0;
    bus_l.port_id = 8'h00; bus_l.out_port = 8'h00; bus_l.io_strb = 1'b0;
    src_p = 4'b0000; src_l = 4'b0000; reset_n = 1'b0;
    test_reset();
    test_single_edge();
    test_two_sources();
    test_masked();
    test_ack_collision();
    test_level();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
